cio_bus_ctrl: RTL and testbench

- Host-bus register controller for the CIO port. It sits between the 8-bit asynchronous host bus (ADDR[1:0], DATA, nWR, nRD) and the CIO output-data/config/input-data registers plus the LED register.
- Host strobes are synchronised into CLK. Each write or read is sequenced through a small FSM.
- The 10-bit CIO registers are exposed through an index register and a low/high byte pair with atomic commit and coherent read.

---
 rtl/cio_bus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cio_bus_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cio_bus_ctrl.sv
// cio_bus_ctrl: host-bus register controller for the CIO port.
// Synchronised host strobes drive a small FSM over indexed 10-bit registers.
module cio_bus_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [9:0] ODR_RST     = 10'h0FF,
    parameter logic [1:0] LED_RST     = 2'b11
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] ADDR,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic       nWR,
    input  logic       nRD,
    input  logic [9:0] CIO_IDR,
    output logic [9:0] CIO_ODR,
    output logic [9:0] CIO_CFG,
    output logic [1:0] LED
);
    typedef enum logic [2:0] {
        IDLE, WR_EXEC, WR_WAIT, RD_LATCH, RD_WAIT, RD_END
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
    logic wr_s, rd_s;

    logic [9:0] odr, odr_n, cfg, cfg_n;
    logic [1:0] led, led_n, index, index_n;
    logic       autoinc, autoinc_n;
    logic [7:0] stage, stage_n, dout, dout_n;
    logic [1:0] shadow, shadow_n, status, status_n;
    logic [1:0] st_set, st_clr;
    logic       rd_hi, rd_hi_n, armed, armed_n;
    logic [9:0] selected;
    logic [7:0] rd_mux;

    // Sync flops reset to "asserted" so a strobe held low across reset
    // is not accepted until it has been seen high.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], nWR};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], nRD};
        end
    end

    assign wr_s = !wr_sync[SYNC_STAGES-1];
    assign rd_s = !rd_sync[SYNC_STAGES-1];

    always_comb begin
        case (index)
            2'd0:    selected = odr;
            2'd1:    selected = cfg;
            2'd2:    selected = CIO_IDR;
            default: selected = {8'b0, led};
        endcase
    end

    always_comb begin
        case (ADDR)
            2'd0:    rd_mux = {autoinc, 5'b0, index};
            2'd1:    rd_mux = selected[7:0];
            2'd2:    rd_mux = {6'b0, shadow};
            default: rd_mux = {6'b0, status};
        endcase
    end

    always_comb begin
        state_n   = state;
        odr_n     = odr;
        cfg_n     = cfg;
        led_n     = led;
        index_n   = index;
        autoinc_n = autoinc;
        stage_n   = stage;
        shadow_n  = shadow;
        dout_n    = dout;
        rd_hi_n   = rd_hi;
        st_set    = 2'b00;
        st_clr    = 2'b00;
        armed_n   = armed | (!wr_s && !rd_s);
        case (state)
            IDLE: begin
                if (armed) begin
                    if (wr_s && rd_s) begin
                        st_set[1] = 1'b1;
                        state_n   = WR_WAIT;
                    end else if (wr_s) begin
                        state_n = WR_EXEC;
                    end else if (rd_s) begin
                        state_n = RD_LATCH;
                    end
                end
            end
            WR_EXEC: begin
                state_n = WR_WAIT;
                case (ADDR)
                    2'd0: begin
                        index_n   = DATA_IN[1:0];
                        autoinc_n = DATA_IN[7];
                    end
                    2'd1: stage_n = DATA_IN;
                    2'd2: begin
                        case (index)
                            2'd0:    odr_n = {DATA_IN[1:0], stage};
                            2'd1:    cfg_n = {DATA_IN[1:0], stage};
                            2'd2:    st_set[0] = 1'b1;
                            default: led_n = stage[1:0];
                        endcase
                        if (autoinc) index_n = index + 2'd1;
                    end
                    default: st_clr = DATA_IN[1:0];
                endcase
            end
            WR_WAIT: begin
                if (!wr_s && !rd_s) state_n = IDLE;
            end
            RD_LATCH: begin
                dout_n  = rd_mux;
                rd_hi_n = (ADDR == 2'd2);
                if (ADDR == 2'd1) shadow_n = selected[9:8];
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (wr_s) st_set[1] = 1'b1;
                else if (!rd_s) state_n = RD_END;
            end
            RD_END: begin
                if (autoinc && rd_hi) index_n = index + 2'd1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        status_n = (status & ~st_clr) | st_set;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            odr     <= ODR_RST;
            cfg     <= '0;
            led     <= LED_RST;
            index   <= '0;
            autoinc <= 1'b0;
            stage   <= '0;
            shadow  <= '0;
            status  <= '0;
            dout    <= 8'hFF;
            rd_hi   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            odr     <= odr_n;
            cfg     <= cfg_n;
            led     <= led_n;
            index   <= index_n;
            autoinc <= autoinc_n;
            stage   <= stage_n;
            shadow  <= shadow_n;
            status  <= status_n;
            dout    <= dout_n;
            rd_hi   <= rd_hi_n;
            armed   <= armed_n;
        end
    end

    assign DATA_OE  = !nRD;
    assign DATA_OUT = dout;
    assign CIO_ODR  = odr;
    assign CIO_CFG  = cfg;
    assign LED      = led;
endmodule

// File: tb/tb_cio_bus_ctrl.sv
// tb_cio_bus_ctrl: directed self-checking bench for cio_bus_ctrl.
// Host cycles are driven as timed strobes; expected values are hand-derived.
module tb_cio_bus_ctrl;
    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] ADDR = '0;
    logic [7:0] DATA_IN = '0;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic       nWR = 1'b1;
    logic       nRD = 1'b1;
    logic [9:0] CIO_IDR = '0;
    logic [9:0] CIO_ODR;
    logic [9:0] CIO_CFG;
    logic [1:0] LED;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    cio_bus_ctrl #(.SYNC_STAGES(S)) dut (
        .CLK(CLK), .nRST(nRST), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE), .nWR(nWR), .nRD(nRD),
        .CIO_IDR(CIO_IDR), .CIO_ODR(CIO_ODR),
        .CIO_CFG(CIO_CFG), .LED(LED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = a;
        DATA_IN = d;
        nWR = 1'b0;
        repeat (S + 4) @(posedge CLK);
        @(negedge CLK);
        nWR = 1'b1;
        repeat (S + 3) @(posedge CLK);
    endtask

    task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLK);
        ADDR = a;
        nRD = 1'b0;
        #1 check("data_oe_on", 16'(DATA_OE), 16'h1);
        repeat (S + 4) @(posedge CLK);
        @(negedge CLK);
        d = DATA_OUT;
        nRD = 1'b1;
        repeat (S + 3) @(posedge CLK);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (S + 3) @(posedge CLK);

        check("rst_led", 16'(LED), 16'h3);
        check("rst_cfg", 16'(CIO_CFG), 16'h000);
        check("rst_odr", 16'(CIO_ODR), 16'h0FF);
        check("rst_dout", 16'(DATA_OUT), 16'hFF);
        check("rst_oe", 16'(DATA_OE), 16'h0);
        host_rd(2'd0, rd); check("rst_index", 16'(rd), 16'h00);
        host_rd(2'd1, rd); check("rst_lo", 16'(rd), 16'hFF);
        host_rd(2'd2, rd); check("rst_shadow", 16'(rd), 16'h00);
        host_rd(2'd3, rd); check("rst_status", 16'(rd), 16'h00);

        host_wr(2'd0, 8'h00);
        host_wr(2'd1, 8'h5A);
        check("stage_no_commit", 16'(CIO_ODR), 16'h0FF);
        @(negedge CLK);
        ADDR = 2'd2;
        DATA_IN = 8'h03;
        nWR = 1'b0;
        repeat (S + 1) @(posedge CLK);
        #1 check("odr_before_lat", 16'(CIO_ODR), 16'h0FF);
        @(posedge CLK);
        #1 check("odr_at_lat", 16'(CIO_ODR), 16'h35A);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        nWR = 1'b1;
        repeat (S + 3) @(posedge CLK);
        check("odr_one_commit", 16'(CIO_ODR), 16'h35A);

        host_wr(2'd0, 8'h01);
        host_wr(2'd1, 8'h34);
        host_wr(2'd2, 8'h02);
        check("cfg_write", 16'(CIO_CFG), 16'h234);

        host_wr(2'd0, 8'h02);
        CIO_IDR = 10'h2C3;
        host_rd(2'd1, rd); check("idr_lo", 16'(rd), 16'hC3);
        CIO_IDR = 10'h100;
        host_rd(2'd2, rd); check("idr_shadow", 16'(rd), 16'h02);

        host_wr(2'd0, 8'h83);
        host_rd(2'd0, rd); check("index_autoinc", 16'(rd), 16'h83);
        host_wr(2'd1, 8'h01);
        host_wr(2'd2, 8'h00);
        check("led_write", 16'(LED), 16'h1);
        host_rd(2'd0, rd); check("index_wrap", 16'(rd), 16'h80);

        host_wr(2'd0, 8'h02);
        host_wr(2'd1, 8'hEE);
        host_wr(2'd2, 8'h03);
        check("ro_odr", 16'(CIO_ODR), 16'h35A);
        check("ro_cfg", 16'(CIO_CFG), 16'h234);
        check("ro_led", 16'(LED), 16'h1);
        host_rd(2'd3, rd); check("roerr_set", 16'(rd), 16'h01);
        host_wr(2'd3, 8'h01);
        host_rd(2'd3, rd); check("roerr_clr", 16'(rd), 16'h00);

        host_wr(2'd0, 8'h00);
        host_wr(2'd1, 8'h11);
        @(negedge CLK);
        ADDR = 2'd2;
        DATA_IN = 8'h01;
        nWR = 1'b0;
        nRD = 1'b0;
        repeat (S + 4) @(posedge CLK);
        @(negedge CLK);
        nWR = 1'b1;
        nRD = 1'b1;
        repeat (S + 3) @(posedge CLK);
        check("coll_odr", 16'(CIO_ODR), 16'h35A);
        host_rd(2'd3, rd); check("coll_status", 16'(rd), 16'h02);

        host_wr(2'd0, 8'h01);
        host_wr(2'd1, 8'hAA);
        @(negedge CLK);
        ADDR = 2'd2;
        DATA_IN = 8'h03;
        nWR = 1'b0;
        repeat (S + 1) @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_odr", 16'(CIO_ODR), 16'h0FF);
        check("mid_rst_cfg", 16'(CIO_CFG), 16'h000);
        check("mid_rst_led", 16'(LED), 16'h3);
        check("mid_rst_dout", 16'(DATA_OUT), 16'hFF);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (S + 6) @(posedge CLK);
        #1 check("held_strobe_ign", 16'(CIO_CFG), 16'h000);
        @(negedge CLK);
        nWR = 1'b1;
        repeat (S + 3) @(posedge CLK);
        check("held_strobe_cfg", 16'(CIO_CFG), 16'h000);
        host_rd(2'd0, rd); check("post_rst_index", 16'(rd), 16'h00);
        host_rd(2'd3, rd); check("post_rst_status", 16'(rd), 16'h00);
        host_wr(2'd1, 8'h77);
        host_wr(2'd2, 8'h01);
        check("post_rst_write", 16'(CIO_ODR), 16'h177);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
